// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder. The address is either loaded by the host (direct)
// or stepped internally (scan) with a programmable dwell time and wrap index.
module onehot_scan_decoder #(
    parameter int  ADDR_W     = 3,
    parameter int  DWELL_W    = 8,
    parameter bit  ACTIVE_LOW = 1'b0,
    localparam int OUT_W      = 1 << ADDR_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_mode,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [ADDR_W-1:0]  i_last,
    output logic [OUT_W-1:0]   o_selector,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_wrap,
    output logic               o_busy
);

    // state  | meaning
    // IDLE   | block disabled, selector inactive, address parked at 0
    // DIRECT | selector follows host-loaded address
    // SCAN   | address advances after each dwell period, wraps past i_last
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                wrap_d;
    logic [OUT_W-1:0]    selector_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            o_addr      <= '0;
            dwell_cnt_q <= '0;
            o_wrap      <= 1'b0;
            o_busy      <= 1'b0;
            o_selector  <= ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            o_addr      <= addr_d;
            dwell_cnt_q <= dwell_cnt_d;
            o_wrap      <= wrap_d;
            o_busy      <= (state_d != IDLE);
            o_selector  <= selector_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = o_addr;
        dwell_cnt_d = dwell_cnt_q;
        wrap_d      = 1'b0;

        if (!i_en) begin
            state_d     = IDLE;
            addr_d      = '0;
            dwell_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_mode) begin
                        state_d     = SCAN;
                        addr_d      = '0;
                        dwell_cnt_d = '0;
                    end else begin
                        state_d = DIRECT;
                        addr_d  = i_addr;
                    end
                end
                DIRECT: begin
                    if (i_mode) begin
                        state_d     = SCAN;
                        addr_d      = '0;
                        dwell_cnt_d = '0;
                    end else if (i_load) begin
                        addr_d = i_addr;
                    end
                end
                SCAN: begin
                    if (!i_mode) begin
                        state_d     = DIRECT;
                        addr_d      = i_addr;
                        dwell_cnt_d = '0;
                    end else if (i_load) begin
                        addr_d      = i_addr;
                        dwell_cnt_d = '0;
                    end else if (dwell_cnt_q == i_dwell) begin
                        // '>=' so a lowered i_last mid-scan still returns to 0
                        dwell_cnt_d = '0;
                        if (o_addr >= i_last) begin
                            addr_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            addr_d = o_addr + 1'b1;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    addr_d      = '0;
                    dwell_cnt_d = '0;
                end
            endcase
        end
    end

    // Decode the next address so the registered selector always matches o_addr and state.
    always_comb begin
        selector_d = '0;
        if (state_d != IDLE) begin
            selector_d[addr_d] = 1'b1;
        end
        if (ACTIVE_LOW) begin
            selector_d = ~selector_d;
        end
    end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: an 8-output active-high instance and a
// 16-output active-low instance, checked with immediate assertions.
module tb_onehot_scan_decoder;

    logic        clk;
    logic        rst_n;

    logic        en, mode, load;
    logic [2:0]  addr, last;
    logic [7:0]  dwell;
    logic [7:0]  sel;
    logic [2:0]  oaddr;
    logic        wrap, busy;

    logic        b_en, b_mode, b_load;
    logic [3:0]  b_addr, b_last;
    logic [7:0]  b_dwell;
    logic [15:0] b_sel;
    logic [3:0]  b_oaddr;
    logic        b_wrap, b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    onehot_scan_decoder #(.ADDR_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_addr(addr),
        .i_load(load), .i_dwell(dwell), .i_last(last),
        .o_selector(sel), .o_addr(oaddr), .o_wrap(wrap), .o_busy(busy)
    );

    onehot_scan_decoder #(.ADDR_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_mode(b_mode), .i_addr(b_addr),
        .i_load(b_load), .i_dwell(b_dwell), .i_last(b_last),
        .o_selector(b_sel), .o_addr(b_oaddr), .o_wrap(b_wrap), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_sel;
        rst_n = 1'b0;
        en = 0; mode = 0; load = 0; addr = 0; last = 3'd7; dwell = 0;
        b_en = 0; b_mode = 0; b_load = 0; b_addr = 0; b_last = 4'd15; b_dwell = 0;
        step(); step();
        check("rst_sel", 32'(sel), 32'h00);
        check("rst_addr", 32'(oaddr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("b_rst_sel", 32'(b_sel), 32'hFFFF);
        rst_n = 1'b1;
        step();
        check("idle_sel", 32'(sel), 32'h00);

        // direct mode
        en = 1; mode = 0; addr = 3'd5;
        step();
        check("dir5_sel", 32'(sel), 32'h20);
        check("dir5_busy", 32'(busy), 32'h1);
        check("dir5_addr", 32'(oaddr), 32'h5);
        addr = 3'd3;
        step();
        check("dir_noload_sel", 32'(sel), 32'h20);
        load = 1; addr = 3'd2;
        step();
        check("dir2_sel", 32'(sel), 32'h04);
        load = 0; en = 0;
        step();
        check("dis_sel", 32'(sel), 32'h00);
        check("dis_busy", 32'(busy), 32'h0);

        // scan dwell=0 last=7
        mode = 1; dwell = 0; last = 3'd7; en = 1;
        step();
        check("s0_entry_sel", 32'(sel), 32'h01);
        check("s0_entry_wrap", 32'(wrap), 32'h0);
        for (int i = 1; i < 8; i++) begin
            step();
            exp_sel = 8'h01 << i;
            check("s0_walk_sel", 32'(sel), 32'(exp_sel));
            check("s0_walk_wrap", 32'(wrap), 32'h0);
        end
        step();
        check("s0_wrap_sel", 32'(sel), 32'h01);
        check("s0_wrap_pulse", 32'(wrap), 32'h1);
        step();
        check("s0_after_sel", 32'(sel), 32'h02);
        check("s0_after_wrap", 32'(wrap), 32'h0);
        en = 0;
        step();

        // scan dwell=2 last=4: 5 addresses x 3 cycles, wrap at cycle 15
        dwell = 8'd2; last = 3'd4; en = 1;
        for (int c = 0; c < 30; c++) begin
            step();
            exp_sel = 8'h01 << ((c / 3) % 5);
            check("s2_sel", 32'(sel), 32'(exp_sel));
            check("s2_wrap", 32'(wrap), (c == 15) ? 32'h1 : 32'h0);
        end
        en = 0;
        step();

        // reseed at address 3
        dwell = 8'd2; last = 3'd7; en = 1;
        step();
        repeat (9) step();
        check("rs_addr3", 32'(oaddr), 32'h3);
        load = 1; addr = 3'd6;
        step();
        load = 0;
        check("rs_sel40", 32'(sel), 32'h40);
        check("rs_wrap0", 32'(wrap), 32'h0);
        step();
        step();
        check("rs_hold40", 32'(sel), 32'h40);
        step();
        check("rs_sel80", 32'(sel), 32'h80);
        step(); step();
        check("rs_hold80", 32'(sel), 32'h80);
        step();
        check("rs_sel01", 32'(sel), 32'h01);
        check("rs_wrap1", 32'(wrap), 32'h1);

        // scan -> direct, then last=0 pins address 0
        mode = 0; addr = 3'd3;
        step();
        check("sd_sel", 32'(sel), 32'h08);
        check("sd_wrap", 32'(wrap), 32'h0);
        mode = 1; dwell = 0; last = 3'd0;
        step();
        check("l0_entry_sel", 32'(sel), 32'h01);
        check("l0_entry_wrap", 32'(wrap), 32'h0);
        step();
        check("l0_sel", 32'(sel), 32'h01);
        check("l0_wrap", 32'(wrap), 32'h1);
        step();
        check("l0_wrap2", 32'(wrap), 32'h1);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_sel", 32'(sel), 32'h00);
        check("ar_addr", 32'(oaddr), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_wrap", 32'(wrap), 32'h0);
        en = 0;
        step();
        rst_n = 1'b1;
        step();

        // active-low 16-output instance
        b_en = 1; b_mode = 0; b_addr = 4'd0;
        step();
        check("b_dir0_sel", 32'(b_sel), 32'hFFFE);
        check("b_dir0_busy", 32'(b_busy), 32'h1);
        b_mode = 1; b_dwell = 0; b_last = 4'd15;
        step();
        check("b_scan_entry", 32'(b_sel), 32'hFFFE);
        repeat (15) step();
        check("b_scan15_sel", 32'(b_sel), 32'h7FFF);
        check("b_scan15_addr", 32'(b_oaddr), 32'hF);
        step();
        check("b_wrap_sel", 32'(b_sel), 32'hFFFE);
        check("b_wrap_pulse", 32'(b_wrap), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
